// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU adder sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_PASS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

  localparam int MUL_STEPS = 3;
  localparam int STEP_W    = 2;

endpackage

// File: rtl/alu_adder_sequencer_arb.sv
// Two-input round-robin arbiter; the pointer flips away from each winner on advance.
module rr_arbiter_2 #(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       gnt_id
);

  logic ptr;

  always_comb begin
    grant  = 2'b00;
    gnt_id = 1'b0;
    if (en) begin
      if (req == 2'b11) begin
        gnt_id = ptr;
        grant  = ptr ? 2'b10 : 2'b01;
      end else if (req[0]) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant  = 2'b10;
        gnt_id = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'(RESET_PRIO);
    end else if (advance) begin
      ptr <= ~gnt_id;
    end
  end

endmodule

// File: rtl/alu_adder_sequencer.sv
// Shares one external 3-bit ripple adder between two requesters (ADD/SUB/MUL/PASS).
// Optional signed-overflow flag output rsp_ovf when ALU_SIGNED_OVF_EN is defined.
//
// state | meaning
// IDLE  | arbitrate and accept one request
// EXEC  | drive adder from registered operands, step counter counts down
// RESP  | hold result until rsp_ready
module alu_adder_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_op,
  input  logic [5:0] req_a,
  input  logic [5:0] req_b,
  output logic [2:0] add_a,
  output logic [2:0] add_b,
  output logic       add_cin,
  input  logic [2:0] add_sum,
  input  logic       add_cout,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [5:0] rsp_data,
`ifdef ALU_SIGNED_OVF_EN
  output logic       rsp_ovf,
`endif
  output logic       rsp_carry
);

  state_e            state, state_nxt;
  op_e               op_q;
  logic [2:0]        a_q, b_q, acc_q;
  logic              id_q;
  logic [STEP_W-1:0] cnt_q;

  logic              gnt_id, accept, step_done;
  logic [1:0]        sel_op;
  logic [2:0]        sel_a, sel_b;
  logic [5:0]        mul_nxt;

  rr_arbiter_2 #(.RESET_PRIO(RESET_PRIO)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (state == IDLE),
    .req    (req_valid),
    .advance(accept),
    .grant  (req_ready),
    .gnt_id (gnt_id)
  );

  assign accept    = |req_ready;
  assign sel_op    = gnt_id ? req_op[3:2] : req_op[1:0];
  assign sel_a     = gnt_id ? req_a[5:3]  : req_a[2:0];
  assign sel_b     = gnt_id ? req_b[5:3]  : req_b[2:0];
  assign step_done = (state == EXEC) && (cnt_q == '0);
  // Shift-add step: new partial product bits enter ACC, multiplier shifts out of M.
  assign mul_nxt   = {add_cout, add_sum, b_q[2:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (cnt_q == '0) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    add_a   = 3'b000;
    add_b   = 3'b000;
    add_cin = 1'b0;
    if (state == EXEC) begin
      case (op_q)
        OP_ADD: begin
          add_a = a_q;
          add_b = b_q;
        end
        OP_SUB: begin
          add_a   = a_q;
          add_b   = ~b_q;
          add_cin = 1'b1;
        end
        OP_MUL: begin
          add_a = acc_q;
          add_b = b_q[0] ? a_q : 3'b000;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_ADD;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
`ifdef ALU_SIGNED_OVF_EN
      rsp_ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q  <= op_e'(sel_op);
        a_q   <= sel_a;
        b_q   <= sel_b;
        acc_q <= '0;
        id_q  <= gnt_id;
        cnt_q <= (op_e'(sel_op) == OP_MUL) ? STEP_W'(MUL_STEPS - 1) : '0;
      end
      if (state == EXEC) begin
        if (op_q == OP_MUL) {acc_q, b_q} <= mul_nxt;
        if (cnt_q != '0) cnt_q <= cnt_q - STEP_W'(1);
      end
      if (step_done) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        case (op_q)
          OP_ADD, OP_SUB: begin
            rsp_data  <= {3'b000, add_sum};
            rsp_carry <= add_cout;
          end
          OP_MUL: begin
            rsp_data  <= mul_nxt;
            rsp_carry <= 1'b0;
          end
          default: begin
            rsp_data  <= {3'b000, a_q};
            rsp_carry <= 1'b0;
          end
        endcase
`ifdef ALU_SIGNED_OVF_EN
        rsp_ovf <= ((op_q == OP_ADD) || (op_q == OP_SUB)) &&
                   (add_a[2] == add_b[2]) && (add_sum[2] != add_a[2]);
`endif
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_adder_sequencer.sv
// Directed, table-driven bench for alu_adder_sequencer with a behavioural external adder.
module tb_alu_adder_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [3:0] req_op;
  logic [5:0] req_a, req_b;
  logic [2:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry;
  logic [5:0] rsp_data;
`ifdef ALU_SIGNED_OVF_EN
  logic       rsp_ovf;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {3'b000, add_cin};

  alu_adder_sequencer #(.RESET_PRIO(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
`ifdef ALU_SIGNED_OVF_EN
    .rsp_ovf  (rsp_ovf),
`endif
    .rsp_carry(rsp_carry)
  );

  typedef struct {
    int id;
    int op;
    int a;
    int b;
    int data;
    int carry;
    int lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request, wait for grant, then wait for the response; returns edges from accept.
  task automatic run_op(input int id, input int op, input int a, input int b, output int lat);
    int guard;
    req_valid[id]        = 1'b1;
    req_op[id*2 +: 2]    = 2'(op);
    req_a[id*3 +: 3]     = 3'(a);
    req_b[id*3 +: 3]     = 3'(b);
    #1;
    guard = 0;
    while (!req_ready[id] && guard < 20) begin
      step();
      guard++;
    end
    if (guard >= 20) check("grant_timeout", 0, 1);
    step();
    req_valid[id] = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    int lat, guard, exp_id;
    logic [5:0] held;

    tbl[0]  = '{0, 0, 5, 6, 3,  1, 2};
    tbl[1]  = '{1, 1, 2, 5, 5,  0, 2};
    tbl[2]  = '{0, 2, 7, 7, 49, 0, 4};
    tbl[3]  = '{1, 2, 5, 2, 10, 0, 4};
    tbl[4]  = '{0, 3, 6, 1, 6,  0, 2};
    tbl[5]  = '{1, 0, 3, 4, 7,  0, 2};
    tbl[6]  = '{0, 1, 5, 5, 0,  1, 2};
    tbl[7]  = '{1, 1, 0, 1, 7,  0, 2};
    tbl[8]  = '{0, 2, 0, 7, 0,  0, 4};
    tbl[9]  = '{1, 2, 3, 6, 18, 0, 4};
    tbl[10] = '{0, 0, 7, 1, 0,  1, 2};
    tbl[11] = '{1, 3, 3, 0, 3,  0, 2};

    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    step(); step();
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_data",  int'(rsp_data), 0);
    check("rst_rsp_id",    int'(rsp_id), 0);
    check("rst_rsp_carry", int'(rsp_carry), 0);
    check("rst_add",       int'({add_a, add_b, add_cin}), 0);
    check("rst_req_ready", int'(req_ready), 0);
    rst = 1'b0;

    // Round robin: both requesters hold PASS; expect 0,1,0,1.
    req_op = 4'b1111; req_a = {3'd5, 3'd2}; req_valid = 2'b11;
    #1;
    check("rr_first_ready", int'(req_ready), 1);
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (!rsp_valid && guard < 20) begin
        step();
        guard++;
      end
      exp_id = k % 2;
      check("rr_id", int'(rsp_id), exp_id);
      check("rr_data", int'(rsp_data), (exp_id == 0) ? 2 : 5);
      step();
    end
    req_valid = 2'b00;
    step(); step(); step();

    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, lat);
      check($sformatf("v%0d_lat", i),   lat, tbl[i].lat);
      check($sformatf("v%0d_data", i),  int'(rsp_data), tbl[i].data);
      check($sformatf("v%0d_carry", i), int'(rsp_carry), tbl[i].carry);
      check($sformatf("v%0d_id", i),    int'(rsp_id), tbl[i].id);
      step();
      check($sformatf("v%0d_done", i),  int'(rsp_valid), 0);
    end

    // MUL 7*7 adder stepping: add_a = 0,3,5 and add_b = 7,7,7.
    req_valid[0] = 1'b1; req_op[1:0] = 2'b10; req_a[2:0] = 3'd7; req_b[2:0] = 3'd7;
    #1;
    guard = 0;
    while (!req_ready[0] && guard < 20) begin
      step();
      guard++;
    end
    step();
    req_valid[0] = 1'b0;
    check("mul_s0_b", int'(add_b), 7); check("mul_s0_a", int'(add_a), 0);
    step();
    check("mul_s1_b", int'(add_b), 7); check("mul_s1_a", int'(add_a), 3);
    step();
    check("mul_s2_b", int'(add_b), 7); check("mul_s2_a", int'(add_a), 5);
    step();
    check("mul_valid", int'(rsp_valid), 1);
    check("mul_data",  int'(rsp_data), 49);
    check("mul_idle_add", int'({add_a, add_b, add_cin}), 0);
    step();

    // Back-pressure: hold rsp_ready low for 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    run_op(0, 0, 1, 2, lat);
    check("bp_lat", lat, 2);
    held = rsp_data;
    check("bp_data", int'(held), 3);
    req_valid[1] = 1'b1; req_op[3:2] = 2'b11; req_a[5:3] = 3'd4;
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid_held", int'(rsp_valid), 1);
      check("bp_data_held", int'(rsp_data), int'(held));
      check("bp_id_held", int'(rsp_id), 0);
      check("bp_req_ready", int'(req_ready), 0);
    end
    rsp_ready = 1'b1;
    step();
    check("bp_released", int'(rsp_valid), 0);
    guard = 0;
    while (!rsp_valid && guard < 20) begin
      if (req_ready[1]) begin
        step();
        req_valid[1] = 1'b0;
      end else begin
        step();
      end
      guard++;
    end
    req_valid[1] = 1'b0;
    check("bp_next_id", int'(rsp_id), 1);
    check("bp_next_data", int'(rsp_data), 4);
    step();

    // Reset during MUL step 1 discards the operation.
    req_valid[0] = 1'b1; req_op[1:0] = 2'b10; req_a[2:0] = 3'd7; req_b[2:0] = 3'd7;
    #1;
    guard = 0;
    while (!req_ready[0] && guard < 20) begin
      step();
      guard++;
    end
    step();
    req_valid[0] = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mrst_valid", int'(rsp_valid), 0);
    check("mrst_data", int'(rsp_data), 0);
    check("mrst_id", int'(rsp_id), 0);
    check("mrst_carry", int'(rsp_carry), 0);
    check("mrst_add", int'({add_a, add_b, add_cin}), 0);
    check("mrst_ready", int'(req_ready), 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      check("mrst_no_rsp", int'(rsp_valid), 0);
    end
    run_op(0, 0, 1, 1, lat);
    check("mrst_add_lat", lat, 2);
    check("mrst_add_data", int'(rsp_data), 2);
    check("mrst_add_carry", int'(rsp_carry), 0);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
